axis_data_checker_cntr: RTL and testbench

- AXI-Stream sink that consumes frames from the counter-pattern generator and checks them.
- Expected frame: FRAME_LEN beats, data DATA_SEED, DATA_SEED+1, … and tlast on the final beat only.
- Counts good frames and errored beats, and holds sticky error flags.
- Sits at the far end of the loopback/MAC path as the built-in self-test receiver.

---
 rtl/axis_checker_pkg.sv | 22 ++
 rtl/axis_checker_lfsr.sv | 26 ++
 rtl/axis_data_checker_cntr.sv | 179 +++++++++++++++++
 tb/tb_axis_data_checker_cntr.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_checker_pkg.sv
// Shared definitions for the AXI-Stream counter-pattern checker:
// FSM state encoding and the backpressure LFSR constants.
package axis_checker_pkg;

    localparam int STATE_WIDTH = 2;

    typedef enum logic [STATE_WIDTH-1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        RESYNC = 2'd2
    } state_t;

    localparam int                    LFSR_WIDTH = 16;
    localparam logic [LFSR_WIDTH-1:0] LFSR_SEED  = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS  = 16'hB400;

    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] cur);
        return {cur[LFSR_WIDTH-2:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/axis_checker_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; its low bit drives random backpressure
// on the checker's tready when AXIS_CHECKER_BP_EN is defined.
module axis_checker_lfsr
    import axis_checker_pkg::*;
(
    input  logic clk_i,
    input  logic a_rst_n_i,
    output logic bit_o
);

    logic [LFSR_WIDTH-1:0] lfsr_q;
    logic [LFSR_WIDTH-1:0] lfsr_d;

    assign lfsr_d = lfsr_next(lfsr_q);

    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign bit_o = lfsr_q[0];

endmodule

// File: rtl/axis_data_checker_cntr.sv
// AXI-Stream sink that checks FRAME_LEN-beat counter frames starting at DATA_SEED,
// counts good frames and errored beats. Optional macro AXIS_CHECKER_BP_EN adds random backpressure.
module axis_data_checker_cntr
    import axis_checker_pkg::*;
#(
    parameter int                         AXIS_DATA_WIDTH = 32,
    parameter int                         FRAME_LEN       = 16,
    parameter logic [AXIS_DATA_WIDTH-1:0] DATA_SEED       = '0,
    parameter int                         CNT_WIDTH       = 32
) (
    input  logic                         clk_i,
    input  logic                         a_rst_n_i,
    input  logic                         enable_i,
    input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata_i,
    input  logic [AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep_i,
    input  logic                         s_axis_tvalid_i,
    input  logic                         s_axis_tlast_i,
    output logic                         s_axis_tready_o,
    input  logic                         err_clr_i,
    output logic [CNT_WIDTH-1:0]         frame_cnt_o,
    output logic [CNT_WIDTH-1:0]         err_cnt_o,
    output logic                         data_err_o,
    output logic                         last_err_o,
    output logic                         frame_done_o,
    output logic                         frame_ok_o,
    output logic                         busy_o
);

    localparam int                IDX_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_t                       state_q, state_d;
    logic [IDX_W-1:0]             index_q, index_d;
    logic [AXIS_DATA_WIDTH-1:0]   exp_data_q, exp_data_d;
    logic [CNT_WIDTH-1:0]         frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0]         err_cnt_q, err_cnt_d;
    logic                         data_err_q, data_err_d;
    logic                         last_err_q, last_err_d;
    logic                         frame_done_q, frame_ok_q;
    logic                         run_q;

    logic tready;
    logic accept;
    logic data_bad;
    logic last_bad;
    logic frame_end;
    logic frame_good;
    logic beat_err;
    logic derr_set;
    logic lerr_set;

    // Byte enables carry no information for a full-width counter pattern
    logic unused_tkeep;
    assign unused_tkeep = ^s_axis_tkeep_i;

    // tready stays low while reset is asserted and for the first clock after release
    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

`ifdef AXIS_CHECKER_BP_EN
    logic lfsr_bit;

    axis_checker_lfsr u_lfsr (
        .clk_i     (clk_i),
        .a_rst_n_i (a_rst_n_i),
        .bit_o     (lfsr_bit)
    );

    assign tready = enable_i && run_q && lfsr_bit;
`else
    assign tready = enable_i && run_q;
`endif

    assign s_axis_tready_o = tready;
    assign accept          = s_axis_tvalid_i && tready;
    assign data_bad        = (s_axis_tdata_i != exp_data_q);
    assign last_bad        = (s_axis_tlast_i != (index_q == LAST_IDX));

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        exp_data_d = exp_data_q;
        frame_end  = 1'b0;
        frame_good = 1'b0;
        beat_err   = 1'b0;
        derr_set   = 1'b0;
        lerr_set   = 1'b0;

        if (accept) begin
            index_d    = index_q + 1'b1;
            exp_data_d = exp_data_q + 1'b1;

            case (state_q)
                IDLE, RECV: begin
                    beat_err = data_bad || last_bad;
                    derr_set = data_bad;
                    lerr_set = last_bad;
                    if (s_axis_tlast_i) begin
                        frame_end  = 1'b1;
                        frame_good = !(data_bad || last_bad);
                        state_d    = IDLE;
                    end else if (data_bad || last_bad) begin
                        state_d = RESYNC;
                    end else begin
                        state_d = RECV;
                    end
                end
                RESYNC: begin
                    if (s_axis_tlast_i) begin
                        frame_end = 1'b1;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (frame_end) begin
                index_d    = '0;
                exp_data_d = DATA_SEED;
            end
        end
    end

    // A clear coinciding with a new error leaves exactly that error recorded
    always_comb begin
        err_cnt_d  = err_cnt_q;
        data_err_d = data_err_q;
        last_err_d = last_err_q;
        if (err_clr_i) begin
            err_cnt_d  = '0;
            data_err_d = 1'b0;
            last_err_d = 1'b0;
        end
        if (beat_err && (err_cnt_d != '1)) begin
            err_cnt_d = err_cnt_d + 1'b1;
        end
        data_err_d  = data_err_d | derr_set;
        last_err_d  = last_err_d | lerr_set;
        frame_cnt_d = frame_cnt_q + CNT_WIDTH'(frame_good);
    end

    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            state_q      <= IDLE;
            index_q      <= '0;
            exp_data_q   <= DATA_SEED;
            frame_cnt_q  <= '0;
            err_cnt_q    <= '0;
            data_err_q   <= 1'b0;
            last_err_q   <= 1'b0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            exp_data_q   <= exp_data_d;
            frame_cnt_q  <= frame_cnt_d;
            err_cnt_q    <= err_cnt_d;
            data_err_q   <= data_err_d;
            last_err_q   <= last_err_d;
            frame_done_q <= frame_end;
            frame_ok_q   <= frame_good;
        end
    end

    assign frame_cnt_o  = frame_cnt_q;
    assign err_cnt_o    = err_cnt_q;
    assign data_err_o   = data_err_q;
    assign last_err_o   = last_err_q;
    assign frame_done_o = frame_done_q;
    assign frame_ok_o   = frame_ok_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_axis_data_checker_cntr.sv
// Self-checking bench for axis_data_checker_cntr (FRAME_LEN=4, DATA_SEED=0x10) with a
// frame-level reference model; also builds with AXIS_CHECKER_BP_EN defined.
module tb_axis_data_checker_cntr;

    localparam int          FL   = 4;
    localparam logic [31:0] SEED = 32'h10;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        enable  = 1'b0;
    logic [31:0] tdata   = '0;
    logic [3:0]  tkeep   = 4'hF;
    logic        tvalid  = 1'b0;
    logic        tlast   = 1'b0;
    logic        err_clr = 1'b0;

    logic        s_axis_tready_o;
    logic [31:0] frame_cnt_o;
    logic [31:0] err_cnt_o;
    logic        data_err_o;
    logic        last_err_o;
    logic        frame_done_o;
    logic        frame_ok_o;
    logic        busy_o;

    axis_data_checker_cntr #(
        .AXIS_DATA_WIDTH (32),
        .FRAME_LEN       (FL),
        .DATA_SEED       (SEED),
        .CNT_WIDTH       (32)
    ) dut (
        .clk_i           (clk),
        .a_rst_n_i       (rst_n),
        .enable_i        (enable),
        .s_axis_tdata_i  (tdata),
        .s_axis_tkeep_i  (tkeep),
        .s_axis_tvalid_i (tvalid),
        .s_axis_tlast_i  (tlast),
        .s_axis_tready_o (s_axis_tready_o),
        .err_clr_i       (err_clr),
        .frame_cnt_o     (frame_cnt_o),
        .err_cnt_o       (err_cnt_o),
        .data_err_o      (data_err_o),
        .last_err_o      (last_err_o),
        .frame_done_o    (frame_done_o),
        .frame_ok_o      (frame_ok_o),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] fr_data[$];
    bit          obs_q[$];
    logic [31:0] exp_fcnt = '0;
    logic [31:0] exp_ecnt = '0;
    bit          exp_derr = 1'b0;
    bit          exp_lerr = 1'b0;
    bit          bp_watch = 1'b0;
    int          watch_cycles = 0;
    int          low_cycles = 0;

    always @(negedge clk) begin
        if (frame_done_o) obs_q.push_back(frame_ok_o);
        if (bp_watch && enable) begin
            watch_cycles++;
            if (!s_axis_tready_o) low_cycles++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model: whole-frame evaluation ----------------
    function automatic void build_clean(input int len);
        fr_data.delete();
        for (int i = 0; i < len; i++) fr_data.push_back(SEED + 32'(i));
    endfunction

    // The first beat breaking the rule (data = SEED+i, tlast only at beat FL-1)
    // is the single counted error; everything after it in the frame is ignored.
    function automatic void model_frame(output bit bad, output bit dbad, output bit lbad);
        bit d, l;
        bad = 1'b0; dbad = 1'b0; lbad = 1'b0;
        for (int i = 0; i < fr_data.size(); i++) begin
            d = (fr_data[i] != SEED + 32'(i));
            l = ((i == fr_data.size() - 1) != (i == FL - 1));
            if (d || l) begin
                bad = 1'b1; dbad = d; lbad = l;
                return;
            end
        end
    endfunction

    task automatic account_frame(output bit exp_ok);
        bit bad, d, l;
        model_frame(bad, d, l);
        exp_ok = !bad;
        if (bad) begin
            if (exp_ecnt != '1) exp_ecnt++;
            exp_derr |= d;
            exp_lerr |= l;
        end else begin
            exp_fcnt++;
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic wait_accept();
        int  n;
        bit  acc;
        n = 0; acc = 1'b0;
        while (!acc) begin
            @(negedge clk);
            acc = s_axis_tready_o;
            @(posedge clk); #1;
            n++;
            if (!acc && n > 300) begin
                checks++; errors++;
                $display("FAIL accept_timeout: tready never seen in %0d cycles, required 1", n);
                acc = 1'b1;
            end
        end
    endtask

    task automatic send_range(input int lo, input int hi, input bit gaps);
        int r;
        for (int i = lo; i <= hi; i++) begin
            if (gaps) begin
                tvalid = 1'b0;
                r = $urandom_range(0, 3);
                if (r == 3) begin
                    enable = 1'b0;
                    repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
                    enable = 1'b1;
                end else begin
                    repeat (r) begin @(posedge clk); #1; end
                end
            end
            tvalid = 1'b1;
            tdata  = fr_data[i];
            tlast  = (i == fr_data.size() - 1);
            wait_accept();
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if ({s_axis_tready_o, frame_cnt_o, err_cnt_o, data_err_o, last_err_o,
             frame_done_o, frame_ok_o, busy_o} !== '0)
            begin errors++; $display("FAIL reset_state: got rdy=%b fcnt=%0d ecnt=%0d derr=%b lerr=%b done=%b ok=%b busy=%b, required all 0",
                s_axis_tready_o, frame_cnt_o, err_cnt_o, data_err_o, last_err_o, frame_done_o, frame_ok_o, busy_o); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("reset released");
    endtask

    task automatic test_clean();
        bit ok;
        for (int f = 0; f < 3; f++) begin
            build_clean(FL);
            account_frame(ok);
            send_range(0, FL - 1, 1'b0);
            checks++;
            if ({frame_done_o, frame_ok_o} !== 2'b11)
                begin errors++; $display("FAIL clean_latency: frame %0d done/ok=%b%b, required 11", f, frame_done_o, frame_ok_o); end
            @(posedge clk); #1;
            checks++;
            if (frame_done_o !== 1'b0)
                begin errors++; $display("FAIL clean_pulse_width: frame %0d done=%b, required 0", f, frame_done_o); end
            $display("clean frame %0d sent", f);
        end
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (obs_q.size() != 3 || obs_q.sum() with (int'(item)) != 3)
            begin errors++; $display("FAIL clean_pulses: %0d pulses, required 3 ok pulses", obs_q.size()); end
        obs_q.delete();
        checks++;
        if ({frame_cnt_o, err_cnt_o, data_err_o, last_err_o} !== {exp_fcnt, exp_ecnt, exp_derr, exp_lerr})
            begin errors++; $display("FAIL clean_status: fcnt=%0d ecnt=%0d d=%b l=%b, required %0d %0d %b %b",
                frame_cnt_o, err_cnt_o, data_err_o, last_err_o, exp_fcnt, exp_ecnt, exp_derr, exp_lerr); end
    endtask

    // One errored frame (built by the caller kind) followed by a clean frame
    task automatic test_error_kind(input int kind);
        bit ok;
        string nm;
        for (int f = 0; f < 2; f++) begin
            if (f == 0) begin
                case (kind)
                    0: begin nm = "data_mismatch"; build_clean(FL); fr_data[1] = 32'hFF; end
                    1: begin nm = "early_tlast";   build_clean(2); end
                    default: begin nm = "missing_tlast"; build_clean(6); end
                endcase
            end else begin
                build_clean(FL);
            end
            account_frame(ok);
            send_range(0, fr_data.size() - 1, 1'b1);
            repeat (2) begin @(posedge clk); #1; end
            $display("%s frame %0d len %0d", nm, f, fr_data.size());
            checks++;
            if (obs_q.size() != 1 || obs_q[0] != ok)
                begin errors++; $display("FAIL %s_done: pulses=%0d ok=%b, required 1 pulse ok=%b",
                    nm, obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 1'b0, ok); end
            obs_q.delete();
            checks++;
            if ({frame_cnt_o, err_cnt_o, data_err_o, last_err_o} !== {exp_fcnt, exp_ecnt, exp_derr, exp_lerr})
                begin errors++; $display("FAIL %s_status: fcnt=%0d ecnt=%0d d=%b l=%b, required %0d %0d %b %b",
                    nm, frame_cnt_o, err_cnt_o, data_err_o, last_err_o, exp_fcnt, exp_ecnt, exp_derr, exp_lerr); end
        end
    endtask

    task automatic test_stall_reset();
        bit ok;
        build_clean(FL);
        account_frame(ok);
        send_range(0, 1, 1'b0);
        enable = 1'b0; tvalid = 1'b1; tdata = fr_data[2]; tlast = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({s_axis_tready_o, busy_o} !== 2'b01)
                begin errors++; $display("FAIL stall_cycle%0d: tready=%b busy=%b, required 0 1", c, s_axis_tready_o, busy_o); end
            @(posedge clk); #1;
        end
        enable = 1'b1;
        send_range(2, FL - 1, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        $display("stalled frame resumed");
        checks++;
        if (obs_q.size() != 1 || obs_q[0] != ok || frame_cnt_o !== exp_fcnt)
            begin errors++; $display("FAIL stall_frame: pulses=%0d fcnt=%0d, required 1 ok pulse fcnt=%0d",
                obs_q.size(), frame_cnt_o, exp_fcnt); end
        obs_q.delete();

        build_clean(FL);
        send_range(0, 1, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s_axis_tready_o, frame_cnt_o, err_cnt_o, data_err_o, last_err_o,
             frame_done_o, frame_ok_o, busy_o} !== '0)
            begin errors++; $display("FAIL midframe_reset: rdy=%b fcnt=%0d ecnt=%0d busy=%b, required all 0",
                s_axis_tready_o, frame_cnt_o, err_cnt_o, busy_o); end
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        exp_fcnt = '0; exp_ecnt = '0; exp_derr = 1'b0; exp_lerr = 1'b0;
        checks++;
        if (obs_q.size() != 0)
            begin errors++; $display("FAIL reset_no_done: %0d pulses, required 0", obs_q.size()); end
        build_clean(FL);
        account_frame(ok);
        send_range(0, FL - 1, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        $display("post-reset frame sent");
        checks++;
        if (obs_q.size() != 1 || obs_q[0] != 1'b1 || frame_cnt_o !== 32'd1)
            begin errors++; $display("FAIL post_reset_frame: pulses=%0d fcnt=%0d, required 1 ok pulse fcnt=1",
                obs_q.size(), frame_cnt_o); end
        obs_q.delete();
    endtask

    task automatic test_clear_collision();
        bit ok;
        for (int f = 0; f < 2; f++) begin
            build_clean(2);
            account_frame(ok);
            send_range(0, 1, 1'b0);
        end
        build_clean(FL);
        fr_data[1] = 32'hFF;
        send_range(0, 0, 1'b0);
        err_clr = 1'b1;
        send_range(1, 1, 1'b0);
        err_clr = 1'b0;
        exp_ecnt = 32'd1; exp_derr = 1'b1; exp_lerr = 1'b0;
        checks++;
        if ({err_cnt_o, data_err_o, last_err_o} !== {exp_ecnt, exp_derr, exp_lerr})
            begin errors++; $display("FAIL clear_collision: ecnt=%0d d=%b l=%b, required 1 1 0",
                err_cnt_o, data_err_o, last_err_o); end
        send_range(2, FL - 1, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        $display("collision frame sent");
        checks++;
        if (obs_q.size() != 3 || obs_q[2] != 1'b0 || frame_cnt_o !== exp_fcnt)
            begin errors++; $display("FAIL collision_frame: pulses=%0d fcnt=%0d, required 3 pulses last not ok fcnt=%0d",
                obs_q.size(), frame_cnt_o, exp_fcnt); end
        obs_q.delete();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        exp_ecnt = '0; exp_derr = 1'b0;
        checks++;
        if ({frame_cnt_o, err_cnt_o, data_err_o, last_err_o} !== {exp_fcnt, exp_ecnt, exp_derr, exp_lerr})
            begin errors++; $display("FAIL plain_clear: fcnt=%0d ecnt=%0d d=%b l=%b, required %0d 0 0 0",
                frame_cnt_o, err_cnt_o, data_err_o, last_err_o, exp_fcnt); end
    endtask

    task automatic test_random();
        bit ok;
        int nfr, kind, len;
`ifdef AXIS_CHECKER_BP_EN
        nfr = 100;
`else
        nfr = 40;
`endif
        bp_watch = 1'b1;
        for (int f = 0; f < nfr; f++) begin
            kind = $urandom_range(0, 3);
            len  = (kind == 2) ? $urandom_range(1, 7) : FL;
            build_clean(len);
            if (kind == 3) fr_data[$urandom_range(0, FL - 1)] ^= (32'h1 << $urandom_range(0, 31));
            account_frame(ok);
            send_range(0, len - 1, 1'b1);
            repeat (2) begin @(posedge clk); #1; end
            $display("random frame %0d len %0d expect_ok %0b", f, len, ok);
            checks++;
            if (obs_q.size() != 1 || obs_q[0] != ok)
                begin errors++; $display("FAIL random_done%0d: pulses=%0d ok=%b, required 1 pulse ok=%b",
                    f, obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 1'b0, ok); end
            obs_q.delete();
            checks++;
            if ({frame_cnt_o, err_cnt_o, data_err_o, last_err_o} !== {exp_fcnt, exp_ecnt, exp_derr, exp_lerr})
                begin errors++; $display("FAIL random_status%0d: fcnt=%0d ecnt=%0d d=%b l=%b, required %0d %0d %b %b",
                    f, frame_cnt_o, err_cnt_o, data_err_o, last_err_o, exp_fcnt, exp_ecnt, exp_derr, exp_lerr); end
        end
        bp_watch = 1'b0;
        checks++;
`ifdef AXIS_CHECKER_BP_EN
        if (low_cycles == 0 || low_cycles == watch_cycles)
            begin errors++; $display("FAIL backpressure: tready low %0d of %0d enabled cycles, required some but not all",
                low_cycles, watch_cycles); end
`else
        if (low_cycles != 0)
            begin errors++; $display("FAIL tready_follows_enable: tready low %0d of %0d enabled cycles, required 0",
                low_cycles, watch_cycles); end
`endif
    endtask

    initial begin
        test_reset();
        test_clean();
        test_error_kind(0);
        test_error_kind(1);
        test_error_kind(2);
        test_stall_reset();
        test_clear_collision();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
